// File: rtl/pointrender_stream.sv
// Streaming world-to-screen point projector: yaw/pitch rotation followed by a
// bit-serial restoring divide for perspective. One point is in flight at a time.
module pointrender_stream #(
    parameter int WC       = 12,
    parameter int ANG      = 8,
    parameter int FRAC     = 10,
    parameter int FOCAL    = 256,
    parameter int NEAR     = 4,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int SCX      = 10,
    parameter int SCY      = 9,
    parameter int QW       = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cam_load,
    input  logic signed [WC-1:0] cam_x,
    input  logic signed [WC-1:0] cam_y,
    input  logic signed [WC-1:0] cam_z,
    input  logic [ANG-1:0]       cam_yaw,
    input  logic [ANG-1:0]       cam_pitch,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [WC-1:0] in_x,
    input  logic signed [WC-1:0] in_y,
    input  logic signed [WC-1:0] in_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SCX-1:0]       out_sx,
    output logic [SCY-1:0]       out_sy,
    output logic                 out_visible,
    output logic                 busy
);
    localparam int DW   = WC + 1;
    localparam int RW   = WC + 2;
    localparam int TW   = FRAC + 2;
    localparam int AW1  = DW + TW + 1;
    localparam int AW2  = RW + TW + 1;
    localparam int QTR  = 2 ** (ANG - 2);
    localparam int FL   = $clog2(FOCAL);
    localparam int NW   = RW + FL;
    localparam int CW   = NW + QW;
    localparam int PW   = SCX + 2;
    localparam int CNTW = (QW > 1) ? $clog2(QW) : 1;
    localparam logic signed [PW-1:0] HALF_W = PW'(SCREEN_W / 2);
    localparam logic signed [PW-1:0] HALF_H = PW'(SCREEN_H / 2);
    localparam logic signed [PW-1:0] LIM_W  = PW'(SCREEN_W);
    localparam logic signed [PW-1:0] LIM_H  = PW'(SCREEN_H);
    localparam logic signed [RW-1:0] NEAR_Z = RW'(NEAR);

    typedef enum logic [2:0] {IDLE, ROT_Y, ROT_P, DIV_X, DIV_Y, OUT} state_t;
    state_t state, state_nxt;

    logic signed [WC-1:0]  pose_x, pose_y, pose_z;
    logic [ANG-1:0]        pose_yaw, pose_pitch;
    logic signed [DW-1:0]  dx, dy, dz;
    logic signed [TW-1:0]  cy, sy, cp, sp;
    logic signed [RW-1:0]  rx, ry, rz;
    logic [NW-1:0]         rem;
    logic [QW-1:0]         quo;
    logic [CNTW-1:0]       cnt;
    logic                  ovf, neg;
    logic signed [QW:0]    qx;

    // Quarter-wave sine table, entries 0..QTR inclusive so that sin(90deg) is exact.
    logic signed [TW-1:0]  qlut [0:QTR];

    function automatic int qsin(input int k);
        real r;
        r = $sin(3.14159265358979 * real'(k) / real'(2 * QTR));
        return $rtoi(r * real'(2 ** FRAC) + 0.5);
    endfunction

    for (genvar k = 0; k <= QTR; k++) begin : g_lut
        assign qlut[k] = TW'(qsin(k));
    end

    function automatic logic signed [TW-1:0] trig(input logic [ANG-1:0] a);
        logic [ANG-2:0]       k;
        logic signed [TW-1:0] m;
        k = {1'b0, a[ANG-3:0]};
        if (a[ANG-2]) k = (ANG-1)'(QTR) - k;
        m = qlut[k];
        return a[ANG-1] ? -m : m;
    endfunction

    function automatic logic [NW-1:0] div_start(input logic signed [RW-1:0] v);
        logic [RW-1:0] m;
        m = v[RW-1] ? RW'(-v) : RW'(v);
        return NW'(m) << FL;
    endfunction

    // Quotient would not fit in QW bits: result is forced to all ones.
    function automatic logic div_sat(input logic [NW-1:0] n, input logic [RW-1:0] d);
        return CW'(n) >= (CW'(d) << QW);
    endfunction

    function automatic logic [SCX-1:0] clamp_x(input logic signed [PW-1:0] v);
        if (v[PW-1]) return '0;
        if (v >= LIM_W) return SCX'(SCREEN_W - 1);
        return v[SCX-1:0];
    endfunction

    function automatic logic [SCY-1:0] clamp_y(input logic signed [PW-1:0] v);
        if (v[PW-1]) return '0;
        if (v >= LIM_H) return SCY'(SCREEN_H - 1);
        return v[SCY-1:0];
    endfunction

    logic signed [AW1-1:0] acc_yx, acc_yz;
    logic signed [AW2-1:0] acc_py, acc_pz;
    logic signed [RW-1:0]  x1_n, z1_n, y2_n, z2_n;
    logic                  near;

    always_comb begin
        acc_yx = AW1'(dx) * AW1'(cy) - AW1'(dz) * AW1'(sy);
        acc_yz = AW1'(dx) * AW1'(sy) + AW1'(dz) * AW1'(cy);
        x1_n   = RW'(acc_yx >>> FRAC);
        z1_n   = RW'(acc_yz >>> FRAC);
        acc_py = AW2'(dy) * AW2'(cp) - AW2'(rz) * AW2'(sp);
        acc_pz = AW2'(dy) * AW2'(sp) + AW2'(rz) * AW2'(cp);
        y2_n   = RW'(acc_py >>> FRAC);
        z2_n   = RW'(acc_pz >>> FRAC);
        near   = z2_n < NEAR_Z;
    end

    logic [CW-1:0]         dsh;
    logic                  take;
    logic [QW-1:0]         quo_n, qmag;
    logic signed [QW:0]    q_fin;
    logic signed [PW-1:0]  sx_w, sy_w;
    logic                  vis_w;

    always_comb begin
        dsh   = CW'($unsigned(rz)) << cnt;
        take  = CW'(rem) >= dsh;
        quo_n = quo | (take ? (QW'(1) << cnt) : '0);
        qmag  = ovf ? '1 : quo_n;
        q_fin = neg ? -$signed({1'b0, qmag}) : $signed({1'b0, qmag});
        sx_w  = HALF_W + PW'(qx);
        sy_w  = HALF_H - PW'(q_fin);
        vis_w = !sx_w[PW-1] && (sx_w < LIM_W) && !sy_w[PW-1] && (sy_w < LIM_H);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ROT_Y;
            ROT_Y:   state_nxt = ROT_P;
            ROT_P:   state_nxt = near ? OUT : DIV_X;
            DIV_X:   if (cnt == '0) state_nxt = DIV_Y;
            DIV_Y:   if (cnt == '0) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == OUT);
    end

    // Pose and results carry reset values; a load only affects later accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pose_x      <= '0;
            pose_y      <= '0;
            pose_z      <= '0;
            pose_yaw    <= '0;
            pose_pitch  <= '0;
            out_sx      <= '0;
            out_sy      <= '0;
            out_visible <= 1'b0;
        end else begin
            if (cam_load) begin
                pose_x     <= cam_x;
                pose_y     <= cam_y;
                pose_z     <= cam_z;
                pose_yaw   <= cam_yaw;
                pose_pitch <= cam_pitch;
            end
            if (state == ROT_P && near) begin
                out_sx      <= '0;
                out_sy      <= '0;
                out_visible <= 1'b0;
            end else if (state == DIV_Y && cnt == '0) begin
                out_sx      <= clamp_x(sx_w);
                out_sy      <= clamp_y(sy_w);
                out_visible <= vis_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (in_valid) begin
                dx <= DW'(in_x) - DW'(pose_x);
                dy <= DW'(in_y) - DW'(pose_y);
                dz <= DW'(in_z) - DW'(pose_z);
                sy <= trig(pose_yaw);
                cy <= trig(pose_yaw + ANG'(QTR));
                sp <= trig(pose_pitch);
                cp <= trig(pose_pitch + ANG'(QTR));
            end
            ROT_Y: begin
                rx <= x1_n;
                rz <= z1_n;
            end
            ROT_P: begin
                ry  <= y2_n;
                rz  <= z2_n;
                rem <= div_start(rx);
                ovf <= div_sat(div_start(rx), z2_n);
                neg <= rx[RW-1];
                quo <= '0;
                cnt <= CNTW'(QW - 1);
            end
            DIV_X: if (cnt == '0) begin
                qx  <= q_fin;
                rem <= div_start(ry);
                ovf <= div_sat(div_start(ry), rz);
                neg <= ry[RW-1];
                quo <= '0;
                cnt <= CNTW'(QW - 1);
            end else begin
                rem <= take ? NW'(CW'(rem) - dsh) : rem;
                quo <= quo_n;
                cnt <= cnt - CNTW'(1);
            end
            DIV_Y: begin
                rem <= take ? NW'(CW'(rem) - dsh) : rem;
                quo <= quo_n;
                cnt <= cnt - CNTW'(1);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pointrender_stream.sv
// Directed and randomized bench for pointrender_stream against a plain-arithmetic
// projection model.
module tb_pointrender_stream;
    localparam int QW  = 12;
    localparam int SW  = 640;
    localparam int SH  = 480;
    localparam int NEAR = 4;
    localparam real PI = 3.14159265358979;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cam_load = 1'b0;
    logic signed [11:0] cam_x = '0, cam_y = '0, cam_z = '0;
    logic [7:0]         cam_yaw = '0, cam_pitch = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [11:0] in_x = '0, in_y = '0, in_z = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [9:0]         out_sx;
    logic [8:0]         out_sy;
    logic               out_visible;
    logic               busy;

    int ncmp = 0;
    int nfail = 0;
    int mx = 0, my = 0, mz = 0, myaw = 0, mpitch = 0;

    pointrender_stream dut (
        .clk(clk), .rst_n(rst_n), .cam_load(cam_load),
        .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z),
        .cam_yaw(cam_yaw), .cam_pitch(cam_pitch),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sx(out_sx), .out_sy(out_sy), .out_visible(out_visible),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint tsin(input int a);
        real s;
        longint m;
        s = $sin(2.0 * PI * real'(a % 256) / 256.0);
        m = longint'($rtoi((s < 0.0 ? -s : s) * 1024.0 + 0.5));
        return (s < 0.0) ? -m : m;
    endfunction

    function automatic longint tcos(input int a);
        real c;
        longint m;
        c = $cos(2.0 * PI * real'(a % 256) / 256.0);
        m = longint'($rtoi((c < 0.0 ? -c : c) * 1024.0 + 0.5));
        return (c < 0.0) ? -m : m;
    endfunction

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint proj(input longint v, input longint z);
        longint m;
        m = ((v < 0 ? -v : v) * 256) / z;
        if (m > (2 ** QW) - 1) m = (2 ** QW) - 1;
        return (v < 0) ? -m : m;
    endfunction

    function automatic longint wrap12(input longint v);
        longint w;
        w = v & 64'd4095;
        if (w >= 2048) w = w - 4096;
        return w;
    endfunction

    task automatic model(input int x, input int y, input int z,
                         output int esx, output int esy, output int evis, output int elat);
        longint dx, dy, dz, cy, sy, cp, sp, x1, z1, y2, z2, sx, ys;
        dx = x - mx; dy = y - my; dz = z - mz;
        cy = tcos(myaw); sy = tsin(myaw); cp = tcos(mpitch); sp = tsin(mpitch);
        x1 = fdiv(dx * cy - dz * sy, 1024);
        z1 = fdiv(dx * sy + dz * cy, 1024);
        y2 = fdiv(dy * cp - z1 * sp, 1024);
        z2 = fdiv(dy * sp + z1 * cp, 1024);
        if (z2 < NEAR) begin
            esx = 0; esy = 0; evis = 0; elat = 2;
            return;
        end
        sx = wrap12(320 + proj(x1, z2));
        ys = wrap12(240 - proj(y2, z2));
        evis = (sx >= 0 && sx < SW && ys >= 0 && ys < SH) ? 1 : 0;
        esx = int'(sx < 0 ? 0 : (sx > SW - 1 ? SW - 1 : sx));
        esy = int'(ys < 0 ? 0 : (ys > SH - 1 ? SH - 1 : ys));
        elat = 2 + 2 * QW;
    endtask

    task automatic load_pose(input int x, input int y, input int z, input int yaw, input int pitch);
        cam_x = 12'(x); cam_y = 12'(y); cam_z = 12'(z);
        cam_yaw = 8'(yaw); cam_pitch = 8'(pitch);
        cam_load = 1'b1;
        tick;
        cam_load = 1'b0;
        mx = x; my = y; mz = z; myaw = yaw; mpitch = pitch;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            tick;
            cyc++;
        end
    endtask

    task automatic run_point(input int x, input int y, input int z, input string tag,
                             output int gsx, output int gsy, output int gvis);
        int esx, esy, evis, elat, cyc;
        model(x, y, z, esx, esy, evis, elat);
        in_x = 12'(x); in_y = 12'(y); in_z = 12'(z);
        in_valid = 1'b1;
        check({tag, "_in_ready"}, int'(in_ready), 1);
        tick;
        in_valid = 1'b0;
        wait_out(cyc);
        check({tag, "_latency"}, cyc, elat);
        gsx = int'(out_sx); gsy = int'(out_sy); gvis = int'(out_visible);
        check({tag, "_sx"}, gsx, esx);
        check({tag, "_sy"}, gsy, esy);
        check({tag, "_vis"}, gvis, evis);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "_ready_after"}, int'(in_ready), 1);
    endtask

    initial begin
        int gsx, gsy, gvis, cyc, seen;
        int px, py, pz, ya, pi_, x, y, z;

        // reset state
        tick; tick;
        rst_n = 1'b1;
        tick;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sx", int'(out_sx), 0);
        check("rst_sy", int'(out_sy), 0);
        check("rst_vis", int'(out_visible), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 1);

        // basic projection at identity pose
        run_point(10, 5, 100, "t1", gsx, gsy, gvis);
        check("t1_sx_const", gsx, 345);
        check("t1_sy_const", gsy, 228);
        check("t1_vis_const", gvis, 1);

        // quarter-turn yaw brings +x onto the optical axis
        load_pose(0, 0, 0, 64, 0);
        run_point(100, 0, 0, "t2", gsx, gsy, gvis);
        check("t2_sx_const", gsx, 320);
        check("t2_sy_const", gsy, 240);
        check("t2_vis_const", gvis, 1);

        // near-plane clip
        load_pose(0, 0, 0, 0, 0);
        run_point(0, 0, 2, "t3", gsx, gsy, gvis);
        check("t3_sx_const", gsx, 0);
        check("t3_vis_const", gvis, 0);

        // off-screen to the right, clamped
        run_point(300, 0, 100, "t4", gsx, gsy, gvis);
        check("t4_sx_const", gsx, 639);
        check("t4_sy_const", gsy, 240);
        check("t4_vis_const", gvis, 0);

        // backpressure: outputs held, no accept while result pending
        in_x = 12'(10); in_y = 12'(5); in_z = 12'(100);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        wait_out(cyc);
        check("hold_latency", cyc, 26);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_busy", int'(busy), 1);
            check("hold_sx", int'(out_sx), 345);
            check("hold_sy", int'(out_sy), 228);
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("hold_in_ready_after", int'(in_ready), 1);
        check("hold_busy_after", int'(busy), 0);
        check("hold_valid_after", int'(out_valid), 0);
        in_valid = 1'b0;

        // pose load on the accept edge uses the old pose
        in_x = 12'(10); in_y = 12'(0); in_z = 12'(100);
        cam_x = 12'(10); cam_y = '0; cam_z = '0; cam_yaw = '0; cam_pitch = '0;
        in_valid = 1'b1;
        cam_load = 1'b1;
        tick;
        in_valid = 1'b0;
        cam_load = 1'b0;
        wait_out(cyc);
        check("camld_latency", cyc, 26);
        check("camld_sx_old", int'(out_sx), 345);
        check("camld_sy_old", int'(out_sy), 240);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        mx = 10;
        run_point(10, 0, 100, "camld_new", gsx, gsy, gvis);
        check("camld_sx_new", gsx, 320);

        // randomized poses and points
        for (int n = 0; n < 30; n++) begin
            if (n % 3 == 0) begin
                px = int'($urandom_range(400, 0)) - 200;
                py = int'($urandom_range(400, 0)) - 200;
                pz = int'($urandom_range(400, 0)) - 200;
                if ($urandom_range(1, 0) == 0) begin
                    ya = int'($urandom_range(255, 0));
                    pi_ = int'($urandom_range(255, 0));
                end else begin
                    ya = (int'($urandom_range(32, 0)) + 240) % 256;
                    pi_ = (int'($urandom_range(32, 0)) + 240) % 256;
                end
                load_pose(px, py, pz, ya, pi_);
            end
            x = int'($urandom_range(1200, 0)) - 600;
            y = int'($urandom_range(1200, 0)) - 600;
            z = int'($urandom_range(2000, 0)) - 200;
            run_point(x, y, z, "rand", gsx, gsy, gvis);
        end

        // reset during the divide discards the point and clears the pose
        load_pose(50, 20, 0, 0, 0);
        in_x = 12'(10); in_y = 12'(5); in_z = 12'(100);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        check("mid_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_busy", int'(busy), 0);
        tick;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (out_valid) seen++;
        end
        check("mid_no_output", seen, 0);
        check("mid_in_ready", int'(in_ready), 1);
        mx = 0; my = 0; mz = 0; myaw = 0; mpitch = 0;
        run_point(10, 5, 100, "mid_pose0", gsx, gsy, gvis);
        check("mid_pose0_sx", gsx, 345);
        check("mid_pose0_sy", gsy, 228);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
